// File: rtl/hba_serial_tx.sv
// Purpose : HBA bus slave that queues bytes in a 4-entry FIFO and sends them as 8N1 serial frames on txd.
// Latency : bus ack one cycle after select rises; first start bit two cycles after the TXDATA write ack.
// Backpr. : no stall on the bus; a TXDATA write into a full FIFO is dropped and latches the sticky overflow bit.
//
// Ports:
//   hba_clk, hba_resetq        - clock (rising edge) and asynchronous active-low reset
//   hba_abus, hba_rnw, hba_dbus - bus address ([11:8] peripheral, [7:0] register), direction, write data
//   hba_xferack_slave          - one-cycle transfer acknowledge
//   hba_dbus_slave             - read data, zero outside a read ack cycle
//   txd                        - serial output, idle high
//   intr                       - level interrupt: enabled, FIFO empty and transmitter idle
module hba_serial_tx #(
  parameter int         CLK_FREQUENCY = 100_000_000,
  parameter int         BAUD          = 115_200,
  parameter logic [3:0] PERIPH_ADDR   = 4'd1
) (
  input  logic        hba_clk,
  input  logic        hba_resetq,
  input  logic [11:0] hba_abus,
  input  logic        hba_rnw,
  input  logic [7:0]  hba_dbus,
  output logic        hba_xferack_slave,
  output logic [7:0]  hba_dbus_slave,
  output logic        txd,
  output logic        intr
);

  localparam int DIV = CLK_FREQUENCY / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // ---------------------------------------------------------------- bus side
  logic       sel;
  logic       req_done;   // select was already high last cycle: request already taken
  logic       ack_q;
  logic       rnw_q;
  logic [7:0] idx_q;
  logic [7:0] wdat_q;
  logic [7:0] rdata;

  assign sel = (hba_abus[11:8] == PERIPH_ADDR);

  always_ff @(posedge hba_clk or negedge hba_resetq) begin
    if (!hba_resetq) begin
      req_done <= 1'b0;
      ack_q    <= 1'b0;
      rnw_q    <= 1'b1;
      idx_q    <= 8'h00;
      wdat_q   <= 8'h00;
    end else begin
      // Only the first select cycle produces a request; select must drop for a
      // cycle before another one is accepted.
      req_done <= sel;
      ack_q    <= sel & ~req_done;
      if (sel && !req_done) begin
        rnw_q  <= hba_rnw;
        idx_q  <= hba_abus[7:0];
        wdat_q <= hba_dbus;
      end
    end
  end

  // Writes commit at the clock edge that ends the ack cycle.
  logic wr_en, push, stat_wr, ctrl_wr;
  assign wr_en   = ack_q & ~rnw_q;
  assign push    = wr_en & (idx_q == 8'd0);
  assign stat_wr = wr_en & (idx_q == 8'd1);
  assign ctrl_wr = wr_en & (idx_q == 8'd2);

  // ---------------------------------------------------------------- FIFO
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       full, empty, push_ok, pop;
  logic       overflow;
  logic       tx_enable, intr_enable;

  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);
  // Fullness is judged on the count before this cycle, so a same-cycle pop
  // does not rescue a push into a full FIFO.
  assign push_ok = push & ~full;

  always_ff @(posedge hba_clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= wdat_q;
  end

  always_ff @(posedge hba_clk or negedge hba_resetq) begin
    if (!hba_resetq) begin
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      count       <= 3'd0;
      overflow    <= 1'b0;
      tx_enable   <= 1'b1;
      intr_enable <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (push && full)
        overflow <= 1'b1;
      else if (stat_wr && wdat_q[4])
        overflow <= 1'b0;
      if (ctrl_wr) begin
        tx_enable   <= wdat_q[0];
        intr_enable <= wdat_q[1];
      end
    end
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_t     state, next_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    tx_byte;
  logic          tick, start_ok, busy;

  assign tick     = (baud_cnt == '0);
  assign start_ok = ~empty & tx_enable;
  // The head byte leaves the FIFO on the cycle the FSM commits to a new frame.
  assign pop      = start_ok & ((state == IDLE) | ((state == STOP) & tick));

  always_ff @(posedge hba_clk or negedge hba_resetq) begin
    if (!hba_resetq) state <= IDLE;
    else             state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start_ok) next_state = START;
      START: if (tick) next_state = DATA;
      DATA:  if (tick && bit_idx == 3'd7) next_state = STOP;
      STOP:  if (tick) next_state = start_ok ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b1;
    txd  = 1'b1;
    case (state)
      IDLE:    busy = 1'b0;
      START:   txd  = 1'b0;
      DATA:    txd  = tx_byte[bit_idx];
      default: txd  = 1'b1;
    endcase
  end

  // Baud counter reloads at every bit boundary, giving DIV cycles per bit.
  always_ff @(posedge hba_clk or negedge hba_resetq) begin
    if (!hba_resetq) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      tx_byte  <= 8'h00;
    end else begin
      if (pop) begin
        baud_cnt <= BAUD_RELOAD;
        tx_byte  <= fifo_mem[rd_ptr];
      end else if (state != IDLE) begin
        baud_cnt <= tick ? BAUD_RELOAD : baud_cnt - CW'(1);
      end
      // Wraps 7 -> 0 at the end of DATA, ready for the next frame.
      if (state == DATA && tick) bit_idx <= bit_idx + 3'd1;
    end
  end

  // ---------------------------------------------------------------- read mux / outputs
  always_comb begin
    rdata = 8'h00;
    case (idx_q)
      8'd1:    rdata = {3'b000, overflow, busy, count};
      8'd2:    rdata = {6'b000000, intr_enable, tx_enable};
      default: rdata = 8'h00;
    endcase
  end

  assign hba_xferack_slave = ack_q;
  assign hba_dbus_slave    = (ack_q && rnw_q) ? rdata : 8'h00;

  always_ff @(posedge hba_clk or negedge hba_resetq) begin
    if (!hba_resetq) intr <= 1'b0;
    else             intr <= intr_enable & empty & ~busy;
  end

endmodule

// File: tb/tb_hba_serial_tx.sv
// Purpose : self-checking bench for hba_serial_tx at DIV=8 (8 MHz clock, 1 Mbaud).
// Latency : expected bus responses and serial bytes are queued at stimulus time and consumed by monitors.
// Backpr. : none; every wait on the DUT is bounded by a cycle budget.
module tb_hba_serial_tx;

  logic        hba_clk = 1'b0;
  logic        hba_resetq = 1'b1;
  logic [11:0] hba_abus;
  logic        hba_rnw;
  logic [7:0]  hba_dbus;
  logic        hba_xferack_slave;
  logic [7:0]  hba_dbus_slave;
  logic        txd;
  logic        intr;

  hba_serial_tx #(
    .CLK_FREQUENCY(8_000_000),
    .BAUD(1_000_000),
    .PERIPH_ADDR(4'd1)
  ) dut (
    .hba_clk(hba_clk),
    .hba_resetq(hba_resetq),
    .hba_abus(hba_abus),
    .hba_rnw(hba_rnw),
    .hba_dbus(hba_dbus),
    .hba_xferack_slave(hba_xferack_slave),
    .hba_dbus_slave(hba_dbus_slave),
    .txd(txd),
    .intr(intr)
  );

  always #5 hba_clk = ~hba_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge hba_clk) cyc <= cyc + 1;

  typedef struct {bit rd; logic [7:0] d;} bus_exp_t;
  bus_exp_t   bus_q[$];
  logic [7:0] tx_q[$];      // bytes the serial line must still produce, in order
  int         starts[$];    // cycle of each observed start bit
  int         last_start = -1000;

  // Reference model: FIFO contents, sticky overflow, control register.
  logic [7:0] m_fifo[$];
  bit         m_ovf = 1'b0;
  logic [7:0] m_ctrl = 8'h01;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_push(input logic [7:0] b);
    if (m_fifo.size() == 4) m_ovf = 1'b1;
    else m_fifo.push_back(b);
  endfunction

  // An enabled transmitter eventually sends everything queued.
  function automatic void m_drain();
    while (m_ctrl[0] && m_fifo.size() > 0) tx_q.push_back(m_fifo.pop_front());
  endfunction

  // An idle enabled transmitter takes only the head byte when the next one arrives mid-frame.
  function automatic void m_start_one();
    if (m_ctrl[0] && m_fifo.size() > 0) tx_q.push_back(m_fifo.pop_front());
  endfunction

  // Status as seen while the transmitter is idle.
  function automatic logic [7:0] m_status();
    return {3'b000, m_ovf, 1'b0, 3'(m_fifo.size())};
  endfunction

  task automatic bus(input logic [11:0] a, input bit rd, input logic [7:0] wd, input logic [7:0] exp_rd);
    bus_exp_t e;
    int n;
    @(posedge hba_clk); #1;
    hba_abus = a; hba_rnw = rd; hba_dbus = wd;
    e.rd = rd; e.d = exp_rd;
    bus_q.push_back(e);
    for (n = 0; n < 10; n++) begin
      @(negedge hba_clk);
      if (hba_xferack_slave === 1'b1) break;
    end
    checks++;
    if (n == 10) begin
      errors++;
      $display("FAIL bus_ack_timeout addr=%03h waited=%0d cycles required=ack", a, n);
      void'(bus_q.pop_back());
    end
    @(posedge hba_clk); #1;
    hba_abus = 12'h000; hba_rnw = 1'b1; hba_dbus = 8'h00;
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    bus(a, 1'b0, d, 8'h00);
  endtask

  task automatic rd(input logic [11:0] a, input logic [7:0] exp);
    bus(a, 1'b1, 8'h00, exp);
  endtask

  task automatic wait_drain();
    int n;
    for (n = 0; n < 4000 && tx_q.size() > 0; n++) @(negedge hba_clk);
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", tx_q.size());
      tx_q.delete();
    end
    repeat (12) @(negedge hba_clk);
  endtask

  // Bus monitor: every ack consumes one expectation; read data outside a read ack must be zero.
  always @(negedge hba_clk) begin : bus_mon
    bus_exp_t e;
    if (hba_xferack_slave === 1'b1) begin
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack addr=%03h got=ack required=none", hba_abus);
      end else begin
        e = bus_q.pop_front();
        if (e.rd) chk("read_data", hba_dbus_slave, e.d);
      end
    end else begin
      chk("dbus_idle_zero", hba_dbus_slave, 8'h00);
    end
  end

  // Serial decoder: samples mid-bit on the falling clock edge; a frame cut by reset is discarded.
  initial begin : tx_mon
    logic       prev;
    logic [7:0] b;
    bit         ab, start_ok, stop_ok;
    prev = 1'b1;
    forever begin
      @(negedge hba_clk);
      if (hba_resetq === 1'b1 && prev === 1'b1 && txd === 1'b0) begin
        starts.push_back(cyc);
        last_start = cyc;
        ab = 1'b0; b = 8'h00; start_ok = 1'b1; stop_ok = 1'b0;
        for (int off = 1; off <= 76; off++) begin
          @(negedge hba_clk);
          if (hba_resetq !== 1'b1) begin ab = 1'b1; break; end
          if ((off == 4 || off == 7) && txd !== 1'b0) start_ok = 1'b0;
          if (off >= 12 && off <= 68 && ((off - 12) % 8) == 0) b[(off - 12) / 8] = txd;
          if (off == 76) stop_ok = (txd === 1'b1);
        end
        if (!ab) begin
          chk("start_bit_low", start_ok, 1);
          chk("stop_bit_high", stop_ok, 1);
          if (tx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame got=%02h required=no frame", b);
          end else begin
            chk("tx_byte", b, tx_q.pop_front());
          end
        end
      end
      prev = txd;
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog simulation did not finish, required finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus_exp_t   e;
    int         acks, ack_at, acks2, rise, n, ns, lows;
    logic [7:0] c, b;

    hba_abus = 12'h000; hba_rnw = 1'b1; hba_dbus = 8'h00;
    #2 hba_resetq = 1'b0;
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_ack", hba_xferack_slave, 0);
    chk("rst_dbus", hba_dbus_slave, 0);
    chk("rst_intr", intr, 0);
    repeat (3) @(negedge hba_clk);
    hba_resetq = 1'b1;

    rd(12'h101, m_status());
    rd(12'h102, m_ctrl);

    // Single byte A5.
    starts.delete();
    wr(12'h100, 8'hA5); m_push(8'hA5); m_drain();
    wait_drain();
    chk("single_frame_count", starts.size(), 1);
    rd(12'h101, m_status());

    // Held select: exactly one ack on cycle 2; other peripheral never acks.
    e.rd = 1'b1; e.d = m_status(); bus_q.push_back(e);
    @(posedge hba_clk); #1; hba_abus = 12'h101; hba_rnw = 1'b1;
    acks = 0; ack_at = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge hba_clk);
      if (hba_xferack_slave === 1'b1) begin acks++; ack_at = k; end
    end
    @(posedge hba_clk); #1; hba_abus = 12'h201;
    acks2 = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge hba_clk);
      if (hba_xferack_slave === 1'b1) acks2++;
    end
    @(posedge hba_clk); #1; hba_abus = 12'h000;
    chk("hold_ack_count", acks, 1);
    chk("hold_ack_cycle", ack_at, 2);
    chk("other_periph_acks", acks2, 0);

    // Unmapped register index.
    wr(12'h107, 8'hFF);
    rd(12'h102, m_ctrl);
    rd(12'h101, m_status());
    rd(12'h107, 8'h00);
    rd(12'h100, 8'h00);

    // Interrupt: high when idle and empty, low through the frame, back one cycle after STOP.
    wr(12'h102, 8'h03); m_ctrl = 8'h03;
    repeat (2) @(negedge hba_clk);
    chk("intr_idle_enabled", intr, 1);
    wr(12'h100, 8'h3C); m_push(8'h3C); m_drain();
    repeat (2) @(negedge hba_clk);
    rise = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge hba_clk);
      if (intr === 1'b1) begin rise = cyc; break; end
    end
    chk("intr_rise_cycle", rise, last_start + 81);
    wait_drain();
    wr(12'h102, 8'h01); m_ctrl = 8'h01;

    // Overflow and back-to-back frames.
    wr(12'h102, 8'h00); m_ctrl = 8'h00;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i * 8'h11);
      wr(12'h100, b); m_push(b);
    end
    rd(12'h101, m_status());
    starts.delete();
    wr(12'h102, 8'h01); m_ctrl = 8'h01; m_drain();
    wait_drain();
    chk("burst_frame_count", starts.size(), 4);
    if (starts.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("burst_start_spacing", starts[i] - starts[i-1], 80);
    end
    rd(12'h101, m_status());
    wr(12'h101, 8'hEF);
    rd(12'h101, m_status());
    wr(12'h101, 8'h10); m_ovf = 1'b0;
    rd(12'h101, m_status());

    // Disabling mid-frame finishes the frame but starts no other.
    wr(12'h100, 8'h5A); m_push(8'h5A); m_start_one();
    wr(12'h100, 8'hC3); m_push(8'hC3);
    wr(12'h102, 8'h00); m_ctrl = 8'h00;
    wait_drain();
    repeat (100) @(negedge hba_clk);
    rd(12'h101, m_status());
    wr(12'h102, 8'h01); m_ctrl = 8'h01; m_drain();
    wait_drain();
    rd(12'h101, m_status());

    // Randomized fill / drain rounds.
    for (int r = 0; r < 6; r++) begin
      c = {6'b000000, 1'($urandom_range(0, 1)), 1'b0};
      wr(12'h102, c); m_ctrl = c;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        wr(12'h100, b); m_push(b);
      end
      rd(12'h101, m_status());
      rd(12'h102, m_ctrl);
      c = c | 8'h01;
      wr(12'h102, c); m_ctrl = c; m_drain();
      wait_drain();
      chk("rand_intr_after_drain", intr, m_ctrl[1]);
      rd(12'h101, m_status());
      if (m_ovf) begin
        wr(12'h101, 8'h0F);
        rd(12'h101, m_status());
        wr(12'h101, 8'h10); m_ovf = 1'b0;
        rd(12'h101, m_status());
      end
    end
    wr(12'h102, 8'h01); m_ctrl = 8'h01;

    // Reset mid-frame: line high at once, queued bytes and settings discarded.
    wr(12'h102, 8'h00);
    wr(12'h100, 8'h6A);
    for (int i = 0; i < 4; i++) wr(12'h100, 8'h00);
    ns = starts.size();
    wr(12'h102, 8'h03);
    for (n = 0; n < 50 && starts.size() == ns; n++) @(negedge hba_clk);
    chk("reset_frame_started", starts.size(), ns + 1);
    while (cyc < last_start + 30) @(negedge hba_clk);
    chk("pre_reset_txd_low", txd, 0);
    #1 hba_resetq = 1'b0;
    #1;
    chk("midframe_rst_txd", txd, 1);
    chk("midframe_rst_ack", hba_xferack_slave, 0);
    chk("midframe_rst_dbus", hba_dbus_slave, 0);
    chk("midframe_rst_intr", intr, 0);
    repeat (3) @(negedge hba_clk);
    hba_resetq = 1'b1;
    m_fifo.delete(); m_ovf = 1'b0; m_ctrl = 8'h01;
    rd(12'h101, m_status());
    rd(12'h102, m_ctrl);
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge hba_clk);
      if (txd !== 1'b1) lows++;
    end
    chk("no_residual_tx", lows, 0);

    repeat (4) @(negedge hba_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hba_serial_tx.md
HBA_SERIAL_TX -- requirements
Module: hba_serial_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQUENCY, default 100_000_000, giving the hba_clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115_200, giving the serial bit rate; DIV = CLK_FREQUENCY/BAUD (integer, >= 2).
REQ-003 The block SHALL have parameter PERIPH_ADDR, default 4'd1, giving the 4-bit peripheral number matched against hba_abus[11:8].
REQ-004 The block SHALL have port hba_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port hba_resetq, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port hba_abus, input, 12 bits: bus address; [11:8] is the peripheral, [7:0] the register index.
REQ-007 The block SHALL have port hba_rnw, input, 1 bit: 1 = read, 0 = write.
REQ-008 The block SHALL have port hba_dbus, input, 8 bits: master write data.
REQ-009 The block SHALL have port hba_xferack_slave, output, 1 bit: transfer-complete strobe.
REQ-010 The block SHALL have port hba_dbus_slave, output, 8 bits: read data, zero whenever hba_xferack_slave is low.
REQ-011 The block SHALL have port txd, output, 1 bit: serial 8N1 output, idle high.
REQ-012 The block SHALL have port intr, output, 1 bit: level interrupt.

Function
REQ-013 Select SHALL be hba_abus[11:8]==PERIPH_ADDR.
REQ-014 Bus handshake: on the first cycle select is high, the block SHALL register the request and assert hba_xferack_slave for exactly one cycle on the next cycle.
REQ-015 No further ack SHALL occur until select has been low for at least one cycle.
REQ-016 Writes SHALL take effect at the end of the ack cycle; read data SHALL be valid during the ack cycle.
REQ-017 Reg 0 (TXDATA, W): a write SHALL push hba_dbus into a 4-entry FIFO; a read SHALL return 0.
REQ-018 Reg 1 (STATUS, R): [2:0] FIFO count 0-4, [3] transmitter busy, [4] sticky overflow, [7:5] 0.
REQ-019 Writing 1 to STATUS[4] SHALL clear overflow; writing 0 SHALL leave it unchanged.
REQ-020 Reg 2 (CTRL, R/W): [0] tx_enable, [1] intr_enable, [7:2] read 0.
REQ-021 Reg indices >= 3 SHALL read 0 and SHALL ignore writes, but SHALL still ack.
REQ-022 Full rule: a push while count==4 (evaluated before the cycle) SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-023 A simultaneous push and pop with count < 4 SHALL leave count unchanged.
REQ-024 FIFO pointers SHALL be 2 bits wide and wrap modulo 4.
REQ-025 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-026 IDLE -> START SHALL occur when the FIFO is non-empty and tx_enable=1; the head byte is popped in that same cycle and txd goes low on the next cycle.
REQ-027 Each bit SHALL last exactly DIV cycles, using a baud counter that reloads at each bit boundary.
REQ-028 DATA SHALL send 8 bits LSB first, using a 3-bit bit index.
REQ-029 STOP SHALL drive txd=1 for DIV cycles.
REQ-030 At the end of STOP, the FSM SHALL go to START if the FIFO is non-empty and tx_enable=1 (back-to-back, no idle gap); otherwise it SHALL go to IDLE.
REQ-031 Clearing tx_enable mid-frame SHALL complete the current frame and SHALL start no new one.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 intr SHALL equal intr_enable & (count==0) & ~busy.
REQ-034 intr SHALL be registered, updating one cycle after its inputs.

Reset
REQ-035 While hba_resetq=0, the block SHALL drive hba_xferack_slave=0, hba_dbus_slave=0, txd=1, intr=0.
REQ-036 Reset SHALL set FSM=IDLE, FIFO count=0, pointers=0, overflow=0, CTRL=8'h01.
REQ-037 Reset asserted mid-frame SHALL abort the frame immediately; txd SHALL return high asynchronously.
REQ-038 Release of reset SHALL be followed by normal operation from the next rising edge.

Verification (CLK_FREQUENCY=8_000_000, BAUD=1_000_000, DIV=8, PERIPH_ADDR=1)
REQ-039 Single byte: write 8'hA5 to 0x100 -> one-cycle ack; txd low 8 cycles, then bits 1,0,1,0,0,1,0,1 at 8 cycles each, then high 8 cycles; STATUS reads 8'h00 afterward.
REQ-040 Overflow: with tx_enable=0, write 0x11,0x22,0x33,0x44,0x55 to 0x100 -> STATUS=8'h14. Then set CTRL=8'h01 -> frames 0x11..0x44 back-to-back, 320 cycles, no idle gap; 0x55 never sent; write 8'h10 to 0x101 -> STATUS=8'h00.
REQ-041 Ack protocol: hold hba_abus=0x101 for 5 cycles -> exactly one ack, on cycle 2; hba_dbus_slave is nonzero only in that cycle; abus=0x201 -> no ack.
REQ-042 Interrupt: write CTRL=8'h03, push one byte -> intr=0 during the frame, intr=1 one cycle after the STOP bit ends.
REQ-043 Reset mid-frame: hba_resetq low at cycle 30 of a frame -> txd=1 immediately; after release, STATUS=8'h00, CTRL=8'h01, no residual transmission.
REQ-044 Unmapped register: write 8'hFF to 0x107 -> ack issued; CTRL and STATUS unchanged; read 0x107 returns 8'h00.
